// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: animated VGA test-pattern source placed between the VGA
// timing block and its colour inputs. It takes the current pixel coordinates
// and produces a registered colour one clock later.
// Mode and scroll offset are latched only on the frame-start pixel (0,0).
// Optional feature macro: VGA_PATTERN_NOISE_EN adds the LFSR noise pattern
// (mode 4). Without it, mode 4 renders black.
module vga_pattern_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int NUM_BARS    = 8,
  parameter int COLOR_W     = 10,
  parameter int CHECK_LOG2  = 5,
  parameter int SCROLL_STEP = 1
) (
  input  logic               iCLK_50M,
  input  logic               iRST_N,
  input  logic               iPix_En,
  input  logic [10:0]        iX,
  input  logic [10:0]        iY,
  input  logic [2:0]         iMode,
  input  logic [7:0]         iLevel,
  input  logic               iScroll_En,
  output logic [COLOR_W-1:0] oRed,
  output logic [COLOR_W-1:0] oGreen,
  output logic [COLOR_W-1:0] oBlue,
  output logic               oFrame_Start,
  output logic [15:0]        oFrame_Cnt
);

  typedef enum logic [2:0] {
    MODE_BARS   = 3'd0,
    MODE_GREY   = 3'd1,
    MODE_CHECK  = 3'd2,
    MODE_RAMP   = 3'd3,
    MODE_NOISE  = 3'd4,
    MODE_BORDER = 3'd5,
    MODE_BLK6   = 3'd6,
    MODE_BLK7   = 3'd7
  } mode_t;

  localparam logic [10:0]        H_A    = 11'(H_ACTIVE);
  localparam logic [10:0]        V_A    = 11'(V_ACTIVE);
  localparam logic [10:0]        STEP   = 11'(SCROLL_STEP);
  localparam logic [10:0]        BAR_W  = 11'(H_ACTIVE / NUM_BARS);
  localparam logic [31:0]        FULL_U = 32'((1 << COLOR_W) - 1);
  localparam logic [31:0]        HM1_U  = 32'(H_ACTIVE - 1);
  localparam logic [COLOR_W-1:0] FULL   = '1;

  mode_t              mode_q;
  mode_t              mode_cur;
  logic [10:0]        offset_q;
  logic [10:0]        offset_inc;
  logic [10:0]        offset_cur;
  logic [10:0]        x_sum;
  logic [10:0]        xe;
  logic [2:0]         bar_idx;
  logic [COLOR_W-1:0] ramp;
  logic               fs;
  logic               active;
  logic               border;
  logic [COLOR_W-1:0] red_d;
  logic [COLOR_W-1:0] green_d;
  logic [COLOR_W-1:0] blue_d;

  assign fs     = iPix_En && (iX == 11'd0) && (iY == 11'd0);
  assign active = (iX < H_A) && (iY < V_A);
  assign border = (iX == 11'd0) || (iX == H_A - 11'd1) ||
                  (iY == 11'd0) || (iY == V_A - 11'd1);

  // Frame-start pixel renders with the freshly loaded mode and offset, so
  // the latched values are bypassed on that cycle.
  always_comb begin
    offset_inc = offset_q + STEP;
    if (offset_inc >= H_A) offset_inc = offset_inc - H_A;
    offset_cur = (fs && iScroll_En) ? offset_inc : offset_q;
    mode_cur   = fs ? mode_t'(iMode) : mode_q;
    x_sum      = iX + offset_cur;
    xe         = (x_sum >= H_A) ? (x_sum - H_A) : x_sum;
    bar_idx    = 3'(xe / BAR_W);
    ramp       = COLOR_W'((32'(xe) * FULL_U) / HM1_U);
  end

`ifdef VGA_PATTERN_NOISE_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_cur;
  logic [15:0] lfsr_nxt;

  // Static noise restarts from the seed every frame; animated noise keeps running.
  always_comb begin
    lfsr_cur = (fs && !iScroll_En) ? LFSR_SEED : lfsr_q;
    lfsr_nxt = {1'b0, lfsr_cur[15:1]} ^ (lfsr_cur[0] ? LFSR_TAPS : 16'h0000);
  end

  // LFSR advances once per consumed active pixel.
  always_ff @(posedge iCLK_50M) begin
    if (!iRST_N) begin
      lfsr_q <= LFSR_SEED;
    end else if (iPix_En && active) begin
      lfsr_q <= lfsr_nxt;
    end
  end
`endif

  // Pattern selection; everything outside the visible area is black.
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (active) begin
      case (mode_cur)
        MODE_BARS: begin
          red_d   = {COLOR_W{bar_idx[2]}};
          green_d = {COLOR_W{bar_idx[1]}};
          blue_d  = {COLOR_W{bar_idx[0]}};
        end
        MODE_GREY: begin
          red_d[COLOR_W-1 -: 8]   = iLevel;
          green_d[COLOR_W-1 -: 8] = iLevel;
          blue_d[COLOR_W-1 -: 8]  = iLevel;
        end
        MODE_CHECK: begin
          if (xe[CHECK_LOG2] ^ iY[CHECK_LOG2]) begin
            red_d   = FULL;
            green_d = FULL;
            blue_d  = FULL;
          end
        end
        MODE_RAMP: begin
          red_d   = ramp;
          green_d = ramp;
          blue_d  = ramp;
        end
`ifdef VGA_PATTERN_NOISE_EN
        MODE_NOISE: begin
          red_d[COLOR_W-1 -: 8]   = lfsr_cur[7:0];
          green_d[COLOR_W-1 -: 8] = lfsr_cur[15:8];
          blue_d[COLOR_W-1 -: 8]  = lfsr_cur[11:4];
        end
`endif
        MODE_BORDER: begin
          if (border) begin
            red_d   = FULL;
            green_d = FULL;
            blue_d  = FULL;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-frame state: mode and scroll offset latch at frame start.
  always_ff @(posedge iCLK_50M) begin
    if (!iRST_N) begin
      mode_q   <= MODE_BARS;
      offset_q <= 11'd0;
    end else if (fs) begin
      mode_q   <= mode_cur;
      offset_q <= offset_cur;
    end
  end

  // Output registers: colour holds while no pixel is strobed.
  always_ff @(posedge iCLK_50M) begin
    if (!iRST_N) begin
      oRed         <= '0;
      oGreen       <= '0;
      oBlue        <= '0;
      oFrame_Start <= 1'b0;
      oFrame_Cnt   <= 16'd0;
    end else begin
      oFrame_Start <= fs;
      if (fs) oFrame_Cnt <= oFrame_Cnt + 16'd1;
      if (iPix_En) begin
        oRed   <= red_d;
        oGreen <= green_d;
        oBlue  <= blue_d;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen: directed scenarios followed by randomized
// sparse pixel traffic, all checked against an arithmetic reference model.
module tb_vga_pattern_gen;

  localparam int H    = 640;
  localparam int V    = 480;
  localparam int NB   = 8;
  localparam int CW   = 10;
  localparam int CL   = 5;
  localparam int STEP = 80;
  localparam int FULL = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pix_en;
  logic [10:0]   x;
  logic [10:0]   y;
  logic [2:0]    mode;
  logic [7:0]    level;
  logic          scroll;
  logic [CW-1:0] red;
  logic [CW-1:0] green;
  logic [CW-1:0] blue;
  logic          fstart;
  logic [15:0]   fcnt;

  int checks = 0;
  int errors = 0;

  int m_mode, m_off, m_cnt, m_lfsr;
  int e_r, e_g, e_b, e_fs;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_ACTIVE(H), .V_ACTIVE(V), .NUM_BARS(NB), .COLOR_W(CW),
    .CHECK_LOG2(CL), .SCROLL_STEP(STEP)
  ) dut (
    .iCLK_50M(clk), .iRST_N(rst_n), .iPix_En(pix_en), .iX(x), .iY(y),
    .iMode(mode), .iLevel(level), .iScroll_En(scroll),
    .oRed(red), .oGreen(green), .oBlue(blue),
    .oFrame_Start(fstart), .oFrame_Cnt(fcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lfsr_step(input int v);
    return (v >> 1) ^ (((v & 1) != 0) ? 'hB400 : 0);
  endfunction

  // Colour of one pixel from the pattern rules, using the model's frame state.
  task automatic model_pixel(input int px, input int py);
    int xe, bar, c;
    e_r = 0; e_g = 0; e_b = 0;
    if (px < H && py < V) begin
      xe = (px + m_off) % H;
      case (m_mode)
        0: begin
          bar = xe / (H / NB);
          e_r = ((bar >> 2) & 1) ? FULL : 0;
          e_g = ((bar >> 1) & 1) ? FULL : 0;
          e_b = (bar & 1) ? FULL : 0;
        end
        1: begin
          c = level * (1 << (CW - 8));
          e_r = c; e_g = c; e_b = c;
        end
        2: begin
          c = (((xe >> CL) ^ (py >> CL)) & 1) ? FULL : 0;
          e_r = c; e_g = c; e_b = c;
        end
        3: begin
          c = (xe * FULL) / (H - 1);
          e_r = c; e_g = c; e_b = c;
        end
`ifdef VGA_PATTERN_NOISE_EN
        4: begin
          e_r = (m_lfsr & 'hFF) << (CW - 8);
          e_g = ((m_lfsr >> 8) & 'hFF) << (CW - 8);
          e_b = ((m_lfsr >> 4) & 'hFF) << (CW - 8);
        end
`endif
        5: begin
          c = (px == 0 || px == H - 1 || py == 0 || py == V - 1) ? FULL : 0;
          e_r = c; e_g = c; e_b = c;
        end
        default: ;
      endcase
    end
  endtask

  // Apply one clock of inputs, advance the model, compare #1 after the edge.
  task automatic drive(input bit rst, input bit en, input int px, input int py,
                       input int md, input int lv, input bit sc);
    bit fs;
    rst_n  = rst;
    pix_en = en;
    x      = 11'(px);
    y      = 11'(py);
    mode   = 3'(md);
    level  = 8'(lv);
    scroll = sc;
    @(posedge clk);
    if (!rst) begin
      m_mode = 0; m_off = 0; m_cnt = 0; m_lfsr = 'hACE1;
      e_r = 0; e_g = 0; e_b = 0; e_fs = 0;
    end else begin
      fs = en && px == 0 && py == 0;
      if (fs) begin
        m_mode = md;
        if (sc) m_off = (m_off + STEP) % H;
        else    m_lfsr = 'hACE1;
        m_cnt = (m_cnt + 1) % 65536;
      end
      e_fs = fs ? 1 : 0;
      if (en) begin
        model_pixel(px, py);
        if (px < H && py < V) m_lfsr = lfsr_step(m_lfsr);
      end
    end
    #1;
    chk("red", red, e_r);
    chk("green", green, e_g);
    chk("blue", blue, e_b);
    chk("frame_start", fstart, e_fs);
    chk("frame_cnt", fcnt, m_cnt);
  endtask

  function automatic int pick(input int lim);
    case ($urandom_range(0, 7))
      0: return 0;
      1: return lim - 1;
      2: return lim;
      default: return $urandom_range(0, lim + 60);
    endcase
  endfunction

  logic [3*CW-1:0] snap;

  initial begin
    // reset, including a simultaneous frame-start pixel
    drive(0, 1, 0, 0, 5, 0, 1);
    drive(0, 1, 0, 0, 5, 0, 1);
    chk("rst_cnt", fcnt, 0);
    chk("rst_fs", fstart, 0);

    // colour bars, scroll off
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 10, 0, 0, 0);
    chk("bar_x0", {red, green, blue}, 30'h0);
    drive(1, 1, 80, 10, 0, 0, 0);
    chk("bar_x80", {red, green, blue}, {10'h0, 10'h0, 10'h3FF});
    drive(1, 1, 240, 10, 0, 0, 0);
    chk("bar_x240", {red, green, blue}, {10'h0, 10'h3FF, 10'h3FF});
    drive(1, 1, 639, 10, 0, 0, 0);
    chk("bar_x639", {red, green, blue}, {10'h3FF, 10'h3FF, 10'h3FF});
    drive(1, 1, 640, 10, 0, 0, 0);

    // scrolling bars over 8 frames wraps the offset back to 0
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 0, 0, 0, 0, 1);
      if (i == 1) chk("scroll_f1_blue", {red, green, blue}, {10'h0, 10'h0, 10'h3FF});
      if (i == 8) chk("scroll_wrap_black", {red, green, blue}, 30'h0);
      drive(1, 1, 600, 200, 0, 0, 1);
    end
    chk("scroll_cnt8", fcnt, 8);

    // mid-frame mode change only lands at the next frame start
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 100, 100, 2, 0, 0);
    chk("midframe_bars", {red, green, blue}, {10'h0, 10'h0, 10'h3FF});
    drive(1, 1, 0, 0, 2, 0, 0);
    chk("checker_fs", fstart, 1);
    drive(1, 1, 32, 0, 2, 0, 0);
    chk("checker_x32", red, 10'h3FF);

    // solid grey, out-of-area and pixel-enable hold
    drive(1, 1, 0, 0, 1, 'h80, 0);
    drive(1, 1, 640, 5, 1, 'h80, 0);
    chk("grey_x640", {red, green, blue}, 30'h0);
    drive(1, 1, 5, 480, 1, 'h80, 0);
    chk("grey_y480", {red, green, blue}, 30'h0);
    drive(1, 1, 100, 100, 1, 'h80, 0);
    chk("grey_200", green, 10'h200);
    for (int i = 0; i < 3; i++) drive(1, 0, 300 + i, 7, 3, 'h11, 1);
    chk("grey_hold", {red, green, blue}, {10'h200, 10'h200, 10'h200});

    // noise: static then animated
    drive(1, 1, 0, 0, 4, 0, 0);
    snap = {red, green, blue};
`ifdef VGA_PATTERN_NOISE_EN
    chk("noise_seed_green", green, 10'h2B0);
`else
    chk("noise_off_black", snap, 30'h0);
`endif
    for (int i = 0; i < 5; i++) drive(1, 1, 10 + i, 3, 4, 0, 0);
    drive(1, 1, 0, 0, 4, 0, 0);
    chk("noise_static_repeat", {red, green, blue}, snap);
    drive(1, 1, 0, 0, 4, 0, 1);
    snap = {red, green, blue};
    for (int i = 0; i < 5; i++) drive(1, 1, 10 + i, 3, 4, 0, 1);
    drive(1, 1, 0, 0, 4, 0, 1);
`ifdef VGA_PATTERN_NOISE_EN
    chk("noise_animated_differs", ({red, green, blue} != snap) ? 1 : 0, 1);
`endif

    // reset in the middle of a border frame
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 5, 0, 0);
      drive(1, 1, 0, 5, 5, 0, 0);
    end
    chk("border_cnt3", fcnt, 3);
    chk("border_edge", blue, 10'h3FF);
    drive(0, 1, 0, 5, 5, 0, 0);
    chk("midrst_black", {red, green, blue}, 30'h0);
    chk("midrst_cnt", fcnt, 0);
    drive(1, 1, 100, 5, 5, 0, 0);
    chk("midrst_mode0", blue, 10'h3FF);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, en;
      int px, py;
      r  = ($urandom_range(0, 499) != 0);
      en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 24) == 0) begin
        px = 0; py = 0;
      end else begin
        px = pick(H); py = pick(V);
      end
      drive(r, en, px, py, $urandom_range(0, 7), $urandom_range(0, 255),
            1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
